// File: rtl/rf_writeback_unit.sv
// Register-file write driver: forms final writeback data, queues it in a
// small FIFO and issues one register-file write per cycle.
module rf_writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [1:0]  wb_src,
    input  logic [2:0]  wb_funct3,
    input  logic [1:0]  wb_addr_lo,
    input  logic        rf_hold,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        wb_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL = DEPTH[AW:0];
    localparam logic [AW-1:0] ONE  = 1;
    localparam logic [AW:0]   INC  = 1;

    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      dat_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             we_q;
    logic [4:0]       rd_out_q;
    logic [31:0]      data_out_q;
    logic             err_q;

    logic        accept;
    logic        illegal;
    logic        push;
    logic        pop;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wdata;

    assign wb_ready = !rst && (cnt_q < FULL);
    assign accept   = wb_valid && wb_ready;
    assign push     = accept && !illegal && (wb_rd != 5'd0);
    assign pop      = !rf_hold && (cnt_q != '0);

    assign shifted = wb_data >> {wb_addr_lo, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = wb_addr_lo[1] ? wb_data[31:16] : wb_data[15:0];

    always_comb begin
        illegal = 1'b0;
        wdata   = wb_data;
        case (wb_src)
            2'b00: wdata = wb_data;
            2'b10: wdata = wb_data + 32'd4;
            2'b01: begin
                case (wb_funct3)
                    3'b000: wdata = {{24{ld_byte[7]}}, ld_byte};
                    3'b100: wdata = {24'd0, ld_byte};
                    3'b001: begin
                        wdata   = {{16{ld_half[15]}}, ld_half};
                        illegal = wb_addr_lo[0];
                    end
                    3'b101: begin
                        wdata   = {16'd0, ld_half};
                        illegal = wb_addr_lo[0];
                    end
                    3'b010: illegal = (wb_addr_lo != 2'b00);
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + INC;
            2'b01:   cnt_d = cnt_q - INC;
            default: cnt_d = cnt_q;
        endcase
    end

    // Payload storage needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr_q]  <= wb_rd;
            dat_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            rd_out_q   <= 5'd0;
            data_out_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= accept && illegal;
            we_q  <= pop;
            if (pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + ONE;
                rd_out_q      <= rd_q[rptr_q];
                data_out_q    <= dat_q[rptr_q];
            end
            if (push) begin
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= wptr_q + ONE;
            end
        end
    end

    always_comb begin
        busy_rs1 = we_q && (rd_out_q == rs1);
        busy_rs2 = we_q && (rd_out_q == rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && rd_q[i] == rs1) busy_rs1 = 1'b1;
            if (vld_q[i] && rd_q[i] == rs2) busy_rs2 = 1'b1;
        end
        if (rs1 == 5'd0) busy_rs1 = 1'b0;
        if (rs2 == 5'd0) busy_rs2 = 1'b0;
    end

    assign rf_we   = we_q;
    assign rf_rd   = rd_out_q;
    assign rf_data = data_out_q;
    assign wb_err  = err_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed-vector bench for rf_writeback_unit.
module tb_rf_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic [1:0]  wb_src = 2'b00;
    logic [2:0]  wb_funct3 = 3'b000;
    logic [1:0]  wb_addr_lo = 2'b00;
    logic        rf_hold = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        wb_err;

    int ntests = 0;
    int nfail  = 0;

    rf_writeback_unit #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_src(wb_src),
        .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo),
        .rf_hold(rf_hold),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs1(rs1), .rs2(rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge.
    task automatic push(input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] d, input logic [2:0] f3,
                        input logic [1:0] lo);
        wb_src = src; wb_rd = rd; wb_data = d;
        wb_funct3 = f3; wb_addr_lo = lo;
        wb_valid = 1'b1;
        cyc();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        ntests++;
        if (wb_ready !== 1'b0) begin
            nfail++; $display("FAIL reset_ready got=%b exp=0", wb_ready);
        end
        ntests++;
        if ({rf_we, rf_rd, rf_data, wb_err} !== 39'd0) begin
            nfail++;
            $display("FAIL reset_outs we=%b rd=%0d data=%h err=%b exp=0",
                     rf_we, rf_rd, rf_data, wb_err);
        end
        rst = 1'b0;
        #1;
        ntests++;
        if (wb_ready !== 1'b1) begin
            nfail++; $display("FAIL reset_release_ready got=%b exp=1", wb_ready);
        end
    endtask

    task automatic test_alu();
        rs1 = 5'd5;
        push(2'b00, 5'd5, 32'h12345678, 3'b000, 2'b00);
        ntests++;
        if (rf_we !== 1'b0 || busy_rs1 !== 1'b1) begin
            nfail++;
            $display("FAIL alu_stored we=%b busy=%b exp we=0 busy=1", rf_we, busy_rs1);
        end
        cyc();
        ntests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h12345678) begin
            nfail++;
            $display("FAIL alu_write we=%b rd=%0d data=%h exp 1/5/12345678",
                     rf_we, rf_rd, rf_data);
        end
        cyc();
        ntests++;
        if (rf_we !== 1'b0 || busy_rs1 !== 1'b0) begin
            nfail++;
            $display("FAIL alu_done we=%b busy=%b exp 0/0", rf_we, busy_rs1);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [1:0]  lo  [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            push(2'b01, 5'd10, 32'h80FF7F01, f3[i], lo[i]);
            cyc();
            ntests++;
            if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_data !== exp[i]) begin
                nfail++;
                $display("FAIL load_%0d we=%b rd=%0d data=%h exp 1/10/%h",
                         i, rf_we, rf_rd, rf_data, exp[i]);
            end
        end
        cyc();
    endtask

    task automatic test_pc4();
        push(2'b10, 5'd1, 32'hFFFFFFFC, 3'b000, 2'b00);
        cyc();
        ntests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd1 || rf_data !== 32'd0) begin
            nfail++;
            $display("FAIL pc4_wrap we=%b rd=%0d data=%h exp 1/1/0",
                     rf_we, rf_rd, rf_data);
        end
        push(2'b00, 5'd0, 32'hDEADBEEF, 3'b000, 2'b00);
        ntests++;
        if (rf_we !== 1'b0 || wb_err !== 1'b0) begin
            nfail++;
            $display("FAIL x0_accept we=%b err=%b exp 0/0", rf_we, wb_err);
        end
        cyc();
        ntests++;
        if (rf_we !== 1'b0 || wb_err !== 1'b0) begin
            nfail++;
            $display("FAIL x0_drop we=%b err=%b exp 0/0", rf_we, wb_err);
        end
    endtask

    task automatic test_hold();
        rf_hold = 1'b1;
        push(2'b00, 5'd7, 32'hAAAA0007, 3'b000, 2'b00);
        push(2'b00, 5'd9, 32'hBBBB0009, 3'b000, 2'b00);
        rs1 = 5'd7; rs2 = 5'd9;
        #1;
        ntests++;
        if (wb_ready !== 1'b0 || rf_we !== 1'b0) begin
            nfail++;
            $display("FAIL hold_full ready=%b we=%b exp 0/0", wb_ready, rf_we);
        end
        ntests++;
        if (busy_rs1 !== 1'b1 || busy_rs2 !== 1'b1) begin
            nfail++;
            $display("FAIL hold_busy b1=%b b2=%b exp 1/1", busy_rs1, busy_rs2);
        end
        rs1 = 5'd9;
        #1;
        ntests++;
        if (busy_rs1 !== 1'b1) begin
            nfail++; $display("FAIL hold_busy_rs1_9 got=%b exp=1", busy_rs1);
        end
        rf_hold = 1'b0;
        cyc();
        ntests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hAAAA0007) begin
            nfail++;
            $display("FAIL hold_pop1 we=%b rd=%0d data=%h exp 1/7/aaaa0007",
                     rf_we, rf_rd, rf_data);
        end
        cyc();
        ntests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'hBBBB0009) begin
            nfail++;
            $display("FAIL hold_pop2 we=%b rd=%0d data=%h exp 1/9/bbbb0009",
                     rf_we, rf_rd, rf_data);
        end
        cyc();
        rs1 = 5'd7;
        #1;
        ntests++;
        if (rf_we !== 1'b0 || busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin
            nfail++;
            $display("FAIL hold_drain we=%b b1=%b b2=%b exp 0/0/0",
                     rf_we, busy_rs1, busy_rs2);
        end
    endtask

    task automatic test_err();
        logic [1:0] src [2] = '{2'b01, 2'b11};
        for (int i = 0; i < 2; i++) begin
            rs1 = 5'd3;
            push(src[i], 5'd3, 32'h11223344, 3'b010, 2'd2);
            ntests++;
            if (wb_err !== 1'b1 || rf_we !== 1'b0 || busy_rs1 !== 1'b0) begin
                nfail++;
                $display("FAIL err_pulse_%0d err=%b we=%b busy=%b exp 1/0/0",
                         i, wb_err, rf_we, busy_rs1);
            end
            cyc();
            ntests++;
            if (wb_err !== 1'b0 || rf_we !== 1'b0 || wb_ready !== 1'b1) begin
                nfail++;
                $display("FAIL err_after_%0d err=%b we=%b ready=%b exp 0/0/1",
                         i, wb_err, rf_we, wb_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rds [3] = '{5'd11, 5'd12, 5'd13};
        for (int i = 0; i < 3; i++) begin
            push(2'b00, rds[i], 32'hC0DE0000 + 32'(i), 3'b000, 2'b00);
            if (i > 0) begin
                ntests++;
                if (rf_we !== 1'b1 || rf_rd !== rds[i-1] || wb_ready !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b_%0d we=%b rd=%0d ready=%b exp 1/%0d/1",
                             i, rf_we, rf_rd, wb_ready, rds[i-1]);
                end
            end
        end
        cyc();
        ntests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd13 || rf_data !== 32'hC0DE0002) begin
            nfail++;
            $display("FAIL b2b_last we=%b rd=%0d data=%h exp 1/13/c0de0002",
                     rf_we, rf_rd, rf_data);
        end
        cyc();
    endtask

    task automatic test_midreset();
        rf_hold = 1'b1;
        push(2'b00, 5'd4, 32'h44, 3'b000, 2'b00);
        push(2'b00, 5'd6, 32'h66, 3'b000, 2'b00);
        rf_hold = 1'b0;
        rst = 1'b1;
        rs1 = 5'd4; rs2 = 5'd6;
        #1;
        ntests++;
        if (wb_ready !== 1'b0) begin
            nfail++; $display("FAIL midrst_ready got=%b exp=0", wb_ready);
        end
        cyc();
        rst = 1'b0;
        #1;
        ntests++;
        if (rf_we !== 1'b0 || busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0 ||
            wb_ready !== 1'b1) begin
            nfail++;
            $display("FAIL midrst_after we=%b b1=%b b2=%b ready=%b exp 0/0/0/1",
                     rf_we, busy_rs1, busy_rs2, wb_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            ntests++;
            if (rf_we !== 1'b0) begin
                nfail++; $display("FAIL midrst_nowrite_%0d we=%b exp=0", i, rf_we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_pc4();
        test_hold();
        test_err();
        test_back_to_back();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
